// File: rtl/rv32i_dmem_arbiter.sv
// Two-requester arbiter for the data port of the RV32I data RAM.
// The MEM stage has priority, and the loader is forced one grant after MAX_WAIT denied cycles.
module rv32i_dmem_arbiter #(
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [3:0]  cpu_be,
    input  logic [29:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_gnt,
    output logic        cpu_rvalid,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,

    input  logic        ldr_req,
    input  logic        ldr_we,
    input  logic [3:0]  ldr_be,
    input  logic [29:0] ldr_addr,
    input  logic [31:0] ldr_wdata,
    output logic        ldr_gnt,
    output logic        ldr_rvalid,
    output logic [31:0] ldr_rdata,

    output logic        d_we,
    output logic [3:0]  d_be,
    output logic [29:0] d_addr,
    output logic [31:0] d_wdata,
    input  logic [31:0] d_rdata,

    output logic [15:0] conflict_cnt
);

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_LDR = 1'b1
    } owner_e;

    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    logic [3:0]  r_wait_cnt;
    logic        r_rd_pending;
    owner_e      r_rd_owner;
    logic [15:0] r_conflict_cnt;

    logic w_ldr_gnt;
    logic w_cpu_gnt;
    logic w_cpu_rd;
    logic w_ldr_rd;
    logic w_conflict;

    // Grants are held low while reset is asserted so the RAM sees no access.
    assign w_ldr_gnt  = reset && ldr_req && (!cpu_req || (r_wait_cnt == WAIT_LIMIT));
    assign w_cpu_gnt  = reset && cpu_req && !w_ldr_gnt;
    assign w_cpu_rd   = w_cpu_gnt && !cpu_we;
    assign w_ldr_rd   = w_ldr_gnt && !ldr_we;
    assign w_conflict = cpu_req && ldr_req;

    assign cpu_gnt   = w_cpu_gnt;
    assign ldr_gnt   = w_ldr_gnt;
    assign cpu_stall = cpu_req && !w_cpu_gnt;

    always_comb begin
        d_we    = 1'b0;
        d_be    = 4'b0000;
        d_addr  = '0;
        d_wdata = '0;
        if (w_ldr_gnt) begin
            d_we    = ldr_we;
            d_be    = ldr_be;
            d_addr  = ldr_addr;
            d_wdata = ldr_wdata;
        end else if (w_cpu_gnt) begin
            d_we    = cpu_we;
            d_be    = cpu_be;
            d_addr  = cpu_addr;
            d_wdata = cpu_wdata;
        end
    end

    // Starvation counter; cleared whenever the loader is served or stops asking.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wait_cnt <= '0;
        end else if (ldr_req && !w_ldr_gnt) begin
            if (r_wait_cnt != WAIT_LIMIT) begin
                r_wait_cnt <= r_wait_cnt + 4'd1;
            end
        end else begin
            r_wait_cnt <= '0;
        end
    end

    // The RAM returns data one cycle after the address, so remember who asked.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_pending <= 1'b0;
            r_rd_owner   <= OWN_CPU;
        end else begin
            r_rd_pending <= w_cpu_rd || w_ldr_rd;
            if (w_ldr_rd) begin
                r_rd_owner <= OWN_LDR;
            end else if (w_cpu_rd) begin
                r_rd_owner <= OWN_CPU;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_conflict_cnt <= '0;
        end else if (w_conflict && (r_conflict_cnt != 16'hFFFF)) begin
            r_conflict_cnt <= r_conflict_cnt + 16'd1;
        end
    end

    assign cpu_rvalid   = r_rd_pending && (r_rd_owner == OWN_CPU);
    assign ldr_rvalid   = r_rd_pending && (r_rd_owner == OWN_LDR);
    assign cpu_rdata    = d_rdata;
    assign ldr_rdata    = d_rdata;
    assign conflict_cnt = r_conflict_cnt;

endmodule

// File: tb/tb_rv32i_dmem_arbiter.sv
// Self-checking bench for rv32i_dmem_arbiter: a RAM fixture behind the data port and a
// cycle-level reference model of the arbitration rules, driven by directed and random steps.
module tb_rv32i_dmem_arbiter;

    localparam int MAX_WAIT = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, ldr_req, ldr_we;
    logic [3:0]  cpu_be, ldr_be;
    logic [29:0] cpu_addr, ldr_addr;
    logic [31:0] cpu_wdata, ldr_wdata;
    logic        cpu_gnt, cpu_rvalid, cpu_stall, ldr_gnt, ldr_rvalid;
    logic [31:0] cpu_rdata, ldr_rdata;
    logic        d_we;
    logic [3:0]  d_be;
    logic [29:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic [15:0] conflict_cnt;

    rv32i_dmem_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_be(ldr_be), .ldr_addr(ldr_addr),
        .ldr_wdata(ldr_wdata), .ldr_gnt(ldr_gnt), .ldr_rvalid(ldr_rvalid),
        .ldr_rdata(ldr_rdata),
        .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
        .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    // Synchronous RAM fixture: 256 words, byte-enabled writes, registered read.
    logic [31:0] ram [256];
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (d_we && d_be[b]) ram[d_addr[7:0]][8*b +: 8] <= d_wdata[8*b +: 8];
        end
        d_rdata <= ram[d_addr[7:0]];
    end

    int nVectors = 0;
    int nMiscompares = 0;

    // Reference model state
    logic [31:0] refMem [256];
    int          mWait = 0;
    int          mConflict = 0;
    bit          mPendCpu = 0;
    bit          mPendLdr = 0;
    logic [31:0] mPendData = '0;
    bit          lastCpuGnt = 0;
    bit          lastLdrGnt = 0;
    bit          obsLdrGnt = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nVectors++;
        assert (obs === exp) else begin
            nMiscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mergeBytes(input logic [31:0] old, input logic [31:0] nw,
                                               input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // One clock cycle: check outputs against the model, clock, advance the model.
    task automatic step();
        bit          eLdr, eCpu, eWe;
        logic [3:0]  eBe;
        logic [29:0] eAddr;
        logic [31:0] eData;
        #1;
        eLdr = ldr_req && (cpu_req == 1'b0 || mWait >= MAX_WAIT);
        eCpu = cpu_req && !eLdr;
        eWe = 0; eBe = '0; eAddr = '0; eData = '0;
        if (eLdr) begin
            eWe = ldr_we; eBe = ldr_be; eAddr = ldr_addr; eData = ldr_wdata;
        end else if (eCpu) begin
            eWe = cpu_we; eBe = cpu_be; eAddr = cpu_addr; eData = cpu_wdata;
        end
        obsLdrGnt = ldr_gnt;
        checkOutput("cpu_gnt", 32'(cpu_gnt), 32'(eCpu));
        checkOutput("ldr_gnt", 32'(ldr_gnt), 32'(eLdr));
        checkOutput("cpu_stall", 32'(cpu_stall), 32'(cpu_req && !eCpu));
        checkOutput("d_we", 32'(d_we), 32'(eWe));
        checkOutput("d_be", 32'(d_be), 32'(eBe));
        checkOutput("d_addr", 32'(d_addr), 32'(eAddr));
        checkOutput("d_wdata", d_wdata, eData);
        checkOutput("cpu_rvalid", 32'(cpu_rvalid), 32'(mPendCpu));
        checkOutput("ldr_rvalid", 32'(ldr_rvalid), 32'(mPendLdr));
        if (mPendCpu) checkOutput("cpu_rdata", cpu_rdata, mPendData);
        if (mPendLdr) checkOutput("ldr_rdata", ldr_rdata, mPendData);
        checkOutput("conflict_cnt", 32'(conflict_cnt), 32'(mConflict));
        @(posedge clk);
        mPendCpu = eCpu && !eWe;
        mPendLdr = eLdr && !eWe;
        if (eCpu || eLdr) begin
            if (eWe) refMem[eAddr[7:0]] = mergeBytes(refMem[eAddr[7:0]], eData, eBe);
            else     mPendData = refMem[eAddr[7:0]];
        end
        if (ldr_req && !eLdr) mWait = (mWait + 1 > MAX_WAIT) ? MAX_WAIT : mWait + 1;
        else                  mWait = 0;
        if (cpu_req && ldr_req && mConflict < 65535) mConflict++;
        lastCpuGnt = eCpu;
        lastLdrGnt = eLdr;
        @(negedge clk);
    endtask

    task automatic setCpu(input bit req, input bit we, input logic [3:0] be,
                          input logic [29:0] addr, input logic [31:0] wdata);
        cpu_req = req; cpu_we = we; cpu_be = be; cpu_addr = addr; cpu_wdata = wdata;
    endtask

    task automatic setLdr(input bit req, input bit we, input logic [3:0] be,
                          input logic [29:0] addr, input logic [31:0] wdata);
        ldr_req = req; ldr_we = we; ldr_be = be; ldr_addr = addr; ldr_wdata = wdata;
    endtask

    task automatic checkResetState();
        checkOutput("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
        checkOutput("rst_ldr_gnt", 32'(ldr_gnt), 32'd0);
        checkOutput("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        checkOutput("rst_ldr_rvalid", 32'(ldr_rvalid), 32'd0);
        checkOutput("rst_d_we", 32'(d_we), 32'd0);
        checkOutput("rst_d_be", 32'(d_be), 32'd0);
        checkOutput("rst_conflict_cnt", 32'(conflict_cnt), 32'd0);
        checkOutput("rst_cpu_stall", 32'(cpu_stall), 32'(cpu_req));
    endtask

    // Random traffic; a requester keeps its fields until it has been granted.
    task automatic applyStimulus(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            if (!cpu_req || lastCpuGnt)
                setCpu($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                       4'($urandom), 30'($urandom_range(0, 255)), $urandom);
            if (!ldr_req || lastLdrGnt)
                setLdr($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
                       4'($urandom), 30'($urandom_range(0, 255)), $urandom);
            step();
        end
    endtask

    initial begin
        int forcedCnt;
        reset = 1'b0;
        setCpu(1, 0, 4'hF, 30'h10, 32'h0);
        setLdr(0, 0, 4'h0, 30'h0, 32'h0);
        @(negedge clk);
        #1 checkResetState();
        setCpu(0, 0, 4'h0, 30'h0, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // Preload the whole RAM through the loader port.
        for (int a = 0; a < 256; a++) begin
            setLdr(1, 1, 4'hF, 30'(a), $urandom);
            step();
        end
        setLdr(1, 1, 4'hF, 30'h10, 32'hDEADBEEF);
        step();
        setLdr(0, 0, 4'h0, 30'h0, 32'h0);

        // CPU read of 0x10 returns the loaded word one cycle later.
        setCpu(1, 0, 4'hF, 30'h10, 32'h0);
        step();
        setCpu(0, 0, 4'h0, 30'h0, 32'h0);
        #1 checkOutput("read_deadbeef", cpu_rdata, 32'hDEADBEEF);
        checkOutput("read_deadbeef_valid", 32'(cpu_rvalid), 32'd1);
        step();

        // Sustained contention: loader forced through every ninth cycle.
        forcedCnt = 0;
        setCpu(1, 0, 4'hF, 30'h21, 32'h0);
        setLdr(1, 0, 4'hF, 30'h22, 32'h0);
        for (int i = 0; i < 20; i++) begin
            step();
            if (obsLdrGnt) forcedCnt++;
        end
        checkOutput("forced_grant_count", 32'(forcedCnt), 32'd2);
        setCpu(0, 0, 4'h0, 30'h0, 32'h0);
        setLdr(0, 0, 4'h0, 30'h0, 32'h0);
        step();

        // Half-word loader write, then CPU reads the lower half back.
        setLdr(1, 1, 4'b0011, 30'h20, 32'h12345678);
        step();
        setLdr(0, 0, 4'h0, 30'h0, 32'h0);
        setCpu(1, 0, 4'hF, 30'h20, 32'h0);
        step();
        setCpu(0, 0, 4'h0, 30'h0, 32'h0);
        #1 checkOutput("half_write_low", 32'(cpu_rdata[15:0]), 32'h5678);
        step();

        // Ownership alternation: cpu read then ldr read.
        setCpu(1, 0, 4'hF, 30'h30, 32'h0);
        step();
        setCpu(0, 0, 4'h0, 30'h0, 32'h0);
        setLdr(1, 0, 4'hF, 30'h31, 32'h0);
        step();
        setLdr(0, 0, 4'h0, 30'h0, 32'h0);
        step();
        step();

        applyStimulus(400);

        // Reset mid-read: pending rvalid must vanish and not reappear.
        setLdr(0, 0, 4'h0, 30'h0, 32'h0);
        setCpu(1, 0, 4'hF, 30'h40, 32'h0);
        step();
        reset = 1'b0;
        #1 checkResetState();
        mWait = 0; mConflict = 0; mPendCpu = 0; mPendLdr = 0;
        lastCpuGnt = 0; lastLdrGnt = 0;
        @(negedge clk);
        #1 checkResetState();
        setCpu(0, 0, 4'h0, 30'h0, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        step();
        step();

        applyStimulus(200);

        // Drive conflict_cnt into saturation and past it.
        setCpu(1, 0, 4'hF, 30'h5, 32'h0);
        setLdr(1, 0, 4'hF, 30'h6, 32'h0);
        for (int i = 0; i < 70000 && mConflict < 65535; i++) step();
        for (int i = 0; i < 3; i++) step();
        #1 checkOutput("conflict_saturated", 32'(conflict_cnt), 32'h0000FFFF);

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
